// File: rtl/click_rr_arbiter.sv
// Two-requester round-robin arbiter in front of one 2-phase click channel.
// Toggle inputs are synchronised into clk_out; bundled data is sampled at grant.
module click_rr_arbiter #(
  parameter int DATA_W      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_out,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              out_req,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ack,
  output logic              busy,
  output logic              gnt_id,
  output logic              err_timeout
);

  localparam int SYNC_N = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e              state_q,    state_d;
  logic                ptr_q,      ptr_d;
  logic                gnt_q,      gnt_d;
  logic                busy_q,     busy_d;
  logic                out_req_q,  out_req_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                ack0_q,     ack0_d;
  logic                ack1_q,     ack1_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                err_q,      err_d;

  logic [SYNC_N-1:0]   r0_sync_q;
  logic [SYNC_N-1:0]   r1_sync_q;
  logic [SYNC_N-1:0]   oa_sync_q;

  logic                r0_s;
  logic                r1_s;
  logic                oa_s;
  logic                pend0_s;
  logic                pend1_s;
  logic                gsel_s;

  // Saturating increment: the counter parks at the timeout value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Synchroniser chains for the three asynchronous toggle inputs.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      r0_sync_q <= '0;
      r1_sync_q <= '0;
      oa_sync_q <= '0;
    end else begin
      r0_sync_q[0] <= req0;
      r1_sync_q[0] <= req1;
      oa_sync_q[0] <= out_ack;
      for (int i = 1; i < SYNC_N; i++) begin
        r0_sync_q[i] <= r0_sync_q[i-1];
        r1_sync_q[i] <= r1_sync_q[i-1];
        oa_sync_q[i] <= oa_sync_q[i-1];
      end
    end
  end

  assign r0_s    = r0_sync_q[SYNC_N-1];
  assign r1_s    = r1_sync_q[SYNC_N-1];
  assign oa_s    = oa_sync_q[SYNC_N-1];
  assign pend0_s = r0_s ^ ack0_q;
  assign pend1_s = r1_s ^ ack1_q;
  // Both pending: pointer decides; otherwise whoever is pending (pend1 alone -> 1).
  assign gsel_s  = (pend0_s && pend1_s) ? ptr_q : pend1_s;

  // Controller state register.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      gnt_q      <= 1'b0;
      busy_q     <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Next-state: grant in IDLE, wait for the matching downstream ack in WAIT.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    ack0_d     = ack0_q;
    ack1_d     = ack1_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pend0_s || pend1_s) begin
          out_data_d = gsel_s ? data1 : data0;
          out_req_d  = ~out_req_q;
          gnt_d      = gsel_s;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ST_WAIT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (oa_s == out_req_q) begin
          if (gnt_q) begin
            ack1_d = ~ack1_q;
          end else begin
            ack0_d = ~ack0_q;
          end
          ptr_d   = ~gnt_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
          // No abort on timeout: the flag only reports the stall.
          if (TO_EN && (cnt_d == CNT_MAX)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign out_req     = out_req_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign gnt_id      = gnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_click_rr_arbiter.sv
// Scoreboard bench for click_rr_arbiter: expected grants are queued when the
// requesters toggle and checked when out_req toggles.
module tb_click_rr_arbiter;

  localparam int DATA_W      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int MAXW        = 40;

  typedef struct packed {
    logic       gnt;
    logic [1:0] data;
  } exp_t;

  logic        clk_out = 1'b0;
  logic        reset   = 1'b1;
  logic        req0    = 1'b0;
  logic        req1    = 1'b0;
  logic        out_ack = 1'b0;
  logic [1:0]  data0   = 2'b00;
  logic [1:0]  data1   = 2'b00;
  logic        ack0, ack1, out_req, busy, gnt_id, err_timeout;
  logic [1:0]  out_data;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  logic m_ack0 = 1'b0;
  logic m_ack1 = 1'b0;
  logic m_oreq = 1'b0;

  click_rr_arbiter #(
    .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_out(clk_out), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
    .busy(busy), .gnt_id(gnt_id), .err_timeout(err_timeout)
  );

  always #5 clk_out = ~clk_out;

  function automatic logic sig(input int sel);
    case (sel)
      0:       return out_req;
      1:       return ack0;
      2:       return ack1;
      default: return busy;
    endcase
  endfunction

  function automatic logic [7:0] out_vec();
    return {ack0, ack1, out_req, out_data, busy, gnt_id, err_timeout};
  endfunction

  // Waits (bounded) for the selected output to change; reports edges taken.
  task automatic wait_change(input int sel, input int max_edges, output int edges, output bit ok);
    logic start_v;
    start_v = sig(sel);
    edges = 0;
    ok = 1'b0;
    for (int i = 0; i < max_edges && !ok; i++) begin
      @(posedge clk_out);
      #1;
      edges++;
      if (sig(sel) !== start_v) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_out);
    n_cmp++;
    if (out_vec() !== 8'h00) begin
      n_bad++; $display("FAIL reset_state: got %h expected %h", out_vec(), 8'h00);
    end
    reset = 1'b0;
    repeat (5) @(posedge clk_out);
    #1;
    n_cmp++;
    if (out_vec() !== 8'h00) begin
      n_bad++; $display("FAIL reset_idle: got %h expected %h", out_vec(), 8'h00);
    end
  endtask

  task automatic test_single();
    int   e; bit ok; exp_t x;
    @(negedge clk_out);
    data0 = 2'b10; req0 = ~req0;
    sb_q.push_back(exp_t'{1'b0, 2'b10});
    wait_change(0, MAXW, e, ok);
    m_oreq = ~m_oreq;
    n_cmp++;
    if (!ok || e != SYNC_STAGES + 1) begin
      n_bad++; $display("FAIL single_req_latency: got %0d edges (ok=%0d) expected %0d", e, ok, SYNC_STAGES + 1);
    end
    x = sb_q.pop_front();
    n_cmp++;
    if ({gnt_id, out_data} !== x) begin
      n_bad++; $display("FAIL single_grant: got %h expected %h", {gnt_id, out_data}, x);
    end
    n_cmp++;
    if ({out_req, busy} !== {m_oreq, 1'b1}) begin
      n_bad++; $display("FAIL single_busy: got %b expected %b", {out_req, busy}, {m_oreq, 1'b1});
    end
    @(negedge clk_out);
    out_ack = ~out_ack;
    wait_change(1, MAXW, e, ok);
    m_ack0 = ~m_ack0;
    n_cmp++;
    if (!ok || e != SYNC_STAGES + 1) begin
      n_bad++; $display("FAIL single_ack_latency: got %0d edges (ok=%0d) expected %0d", e, ok, SYNC_STAGES + 1);
    end
    n_cmp++;
    if ({ack0, ack1, busy} !== {m_ack0, m_ack1, 1'b0}) begin
      n_bad++; $display("FAIL single_ack: got %b expected %b", {ack0, ack1, busy}, {m_ack0, m_ack1, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk_out);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_vec() !== 8'h00) begin
      n_bad++; $display("FAIL async_reset: got %h expected %h", out_vec(), 8'h00);
    end
    req0 = 1'b0; req1 = 1'b0; out_ack = 1'b0;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_oreq = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk_out);
    reset = 1'b0;
    repeat (6) @(posedge clk_out);
    #1;
    n_cmp++;
    if (out_vec() !== 8'h00) begin
      n_bad++; $display("FAIL async_reset_idle: got %h expected %h", out_vec(), 8'h00);
    end
  endtask

  task automatic test_priority();
    int e; bit ok; exp_t x;
    @(negedge clk_out);
    data0 = 2'b01; data1 = 2'b11; req0 = ~req0; req1 = ~req1;
    sb_q.push_back(exp_t'{1'b0, 2'b01});
    sb_q.push_back(exp_t'{1'b1, 2'b11});
    for (int t = 0; t < 2; t++) begin
      wait_change(0, MAXW, e, ok);
      m_oreq = ~m_oreq;
      x = sb_q.pop_front();
      n_cmp++;
      if (!ok || {gnt_id, out_data, out_req} !== {x, m_oreq}) begin
        n_bad++; $display("FAIL prio_grant%0d: got %h expected %h", t, {gnt_id, out_data, out_req}, {x, m_oreq});
      end
      @(negedge clk_out);
      out_ack = ~out_ack;
      wait_change(1 + int'(x.gnt), MAXW, e, ok);
      if (x.gnt) m_ack1 = ~m_ack1; else m_ack0 = ~m_ack0;
      n_cmp++;
      if (!ok || {ack0, ack1} !== {m_ack0, m_ack1}) begin
        n_bad++; $display("FAIL prio_ack%0d: got %b expected %b", t, {ack0, ack1}, {m_ack0, m_ack1});
      end
    end
  endtask

  task automatic test_alternate();
    int e; bit ok; exp_t x; int pushes;
    @(negedge clk_out);
    data0 = 2'b00; data1 = 2'b01; req0 = ~req0; req1 = ~req1;
    sb_q.push_back(exp_t'{1'b0, 2'b00});
    sb_q.push_back(exp_t'{1'b1, 2'b01});
    pushes = 2;
    for (int t = 0; t < 6; t++) begin
      wait_change(0, MAXW, e, ok);
      m_oreq = ~m_oreq;
      x = sb_q.pop_front();
      n_cmp++;
      if (!ok || {gnt_id, out_data} !== x || x.gnt !== 1'(t % 2)) begin
        n_bad++; $display("FAIL alt_grant%0d: got %h expected %h", t, {gnt_id, out_data}, x);
      end
      @(negedge clk_out);
      out_ack = ~out_ack;
      wait_change(1 + int'(x.gnt), MAXW, e, ok);
      if (x.gnt) m_ack1 = ~m_ack1; else m_ack0 = ~m_ack0;
      n_cmp++;
      if (!ok || {ack0, ack1, busy} !== {m_ack0, m_ack1, 1'b0}) begin
        n_bad++; $display("FAIL alt_ack%0d: got %b expected %b", t, {ack0, ack1, busy}, {m_ack0, m_ack1, 1'b0});
      end
      if (pushes < 6) begin
        @(negedge clk_out);
        if (x.gnt) begin
          data1 = 2'(t * 3 + 1); req1 = ~req1;
          sb_q.push_back(exp_t'{1'b1, 2'(t * 3 + 1)});
        end else begin
          data0 = 2'(t * 3 + 2); req0 = ~req0;
          sb_q.push_back(exp_t'{1'b0, 2'(t * 3 + 2)});
        end
        pushes++;
      end
    end
  endtask

  task automatic test_timeout();
    int e; bit ok; exp_t x;
    @(negedge clk_out);
    data0 = 2'b11; req0 = ~req0;
    sb_q.push_back(exp_t'{1'b0, 2'b11});
    wait_change(0, MAXW, e, ok);
    m_oreq = ~m_oreq;
    x = sb_q.pop_front();
    n_cmp++;
    if (!ok || {gnt_id, out_data} !== x) begin
      n_bad++; $display("FAIL to_grant: got %h expected %h", {gnt_id, out_data}, x);
    end
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      @(posedge clk_out);
      #1;
      n_cmp++;
      if ({busy, err_timeout} !== {1'b1, (i == TIMEOUT_CYC)}) begin
        n_bad++; $display("FAIL to_edge%0d: got %b expected %b", i, {busy, err_timeout}, {1'b1, (i == TIMEOUT_CYC)});
      end
    end
    repeat (10) @(posedge clk_out);
    #1;
    n_cmp++;
    if ({busy, err_timeout} !== 2'b11) begin
      n_bad++; $display("FAIL to_hold: got %b expected %b", {busy, err_timeout}, 2'b11);
    end
    @(negedge clk_out);
    out_ack = ~out_ack;
    wait_change(1, MAXW, e, ok);
    m_ack0 = ~m_ack0;
    n_cmp++;
    if (!ok || {ack0, busy, err_timeout} !== {m_ack0, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL to_complete: got %b expected %b", {ack0, busy, err_timeout}, {m_ack0, 1'b0, 1'b1});
    end
    repeat (4) @(posedge clk_out);
    #1;
    n_cmp++;
    if (err_timeout !== 1'b1) begin
      n_bad++; $display("FAIL to_sticky: got %b expected %b", err_timeout, 1'b1);
    end
  endtask

  task automatic test_reset_wait();
    int e; bit ok; exp_t x;
    @(negedge clk_out);
    data0 = 2'b01; req0 = ~req0;
    sb_q.push_back(exp_t'{1'b0, 2'b01});
    wait_change(0, MAXW, e, ok);
    m_oreq = ~m_oreq;
    x = sb_q.pop_front();
    n_cmp++;
    if (!ok || {gnt_id, out_data, busy} !== {x, 1'b1}) begin
      n_bad++; $display("FAIL rw_grant: got %h expected %h", {gnt_id, out_data, busy}, {x, 1'b1});
    end
    @(negedge clk_out);
    data1 = 2'b10; req1 = ~req1;
    sb_q.push_back(exp_t'{1'b1, 2'b10});
    repeat (4) @(posedge clk_out);
    #1;
    n_cmp++;
    if ({ack0, ack1, out_req, busy} !== {m_ack0, m_ack1, m_oreq, 1'b1}) begin
      n_bad++; $display("FAIL rw_other_ack_frozen: got %b expected %b", {ack0, ack1, out_req, busy}, {m_ack0, m_ack1, m_oreq, 1'b1});
    end
    @(negedge clk_out);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_vec() !== 8'h00) begin
      n_bad++; $display("FAIL rw_reset: got %h expected %h", out_vec(), 8'h00);
    end
    req0 = 1'b0; req1 = 1'b0; out_ack = 1'b0;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_oreq = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk_out);
    reset = 1'b0;
    @(negedge clk_out);
    data0 = 2'b11; data1 = 2'b00; req0 = ~req0; req1 = ~req1;
    sb_q.push_back(exp_t'{1'b0, 2'b11});
    sb_q.push_back(exp_t'{1'b1, 2'b00});
    for (int t = 0; t < 2; t++) begin
      wait_change(0, MAXW, e, ok);
      m_oreq = ~m_oreq;
      x = sb_q.pop_front();
      n_cmp++;
      if (!ok || {gnt_id, out_data, out_req} !== {x, m_oreq}) begin
        n_bad++; $display("FAIL rw_after_grant%0d: got %h expected %h", t, {gnt_id, out_data, out_req}, {x, m_oreq});
      end
      @(negedge clk_out);
      out_ack = ~out_ack;
      wait_change(1 + int'(x.gnt), MAXW, e, ok);
      if (x.gnt) m_ack1 = ~m_ack1; else m_ack0 = ~m_ack0;
      n_cmp++;
      if (!ok || {ack0, ack1} !== {m_ack0, m_ack1}) begin
        n_bad++; $display("FAIL rw_after_ack%0d: got %b expected %b", t, {ack0, ack1}, {m_ack0, m_ack1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_priority();
    test_alternate();
    test_timeout();
    test_reset_wait();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
